mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control unit sequencing the single-ALU MIPS datapath: PC, IR, register file, immediate extender, ALU and shared memory.

---
 rtl/mc_ctrl_pkg.sv | 56 +++++
 rtl/mc_ctrl_decode.sv | 89 ++++++++
 rtl/mc_ctrl_fsm.sv | 154 +++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// extender and ALU selects. Also used by the datapath muxes and the extender.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_ORI   = 4'd1,
    CLS_LUI   = 4'd2,
    CLS_ADDIU = 4'd3,
    CLS_LW    = 4'd4,
    CLS_SW    = 4'd5,
    CLS_BEQ   = 4'd6,
    CLS_J     = 4'd7,
    CLS_ILL   = 4'd8
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;

  function automatic logic cls_uses_mem(input cls_e c);
    return (c == CLS_LW) || (c == CLS_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: op/funct -> class, extender mode,
// ALU operation, B-operand select and illegal flag.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] cls_o,
  output logic [1:0] ext_op_o,
  output logic [2:0] alu_ctrl_o,
  output logic       alu_src_b_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o       = CLS_ILL;
    ext_op_o    = EXT_ZERO;
    alu_ctrl_o  = ALU_ADD;
    alu_src_b_o = 1'b0;
    illegal_o   = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: begin
            cls_o      = CLS_R;
            alu_ctrl_o = ALU_ADD;
            illegal_o  = 1'b0;
          end
          FN_SUBU: begin
            cls_o      = CLS_R;
            alu_ctrl_o = ALU_SUB;
            illegal_o  = 1'b0;
          end
          FN_SLT: begin
            cls_o      = CLS_R;
            alu_ctrl_o = ALU_SLT;
            illegal_o  = 1'b0;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        cls_o       = CLS_ORI;
        ext_op_o    = EXT_ZERO;
        alu_ctrl_o  = ALU_OR;
        alu_src_b_o = 1'b1;
        illegal_o   = 1'b0;
      end
      OP_LUI: begin
        cls_o       = CLS_LUI;
        ext_op_o    = EXT_LUI;
        alu_ctrl_o  = ALU_ADD;
        alu_src_b_o = 1'b1;
        illegal_o   = 1'b0;
      end
      OP_ADDIU: begin
        cls_o       = CLS_ADDIU;
        ext_op_o    = EXT_SIGN;
        alu_src_b_o = 1'b1;
        illegal_o   = 1'b0;
      end
      OP_LW: begin
        cls_o       = CLS_LW;
        ext_op_o    = EXT_SIGN;
        alu_src_b_o = 1'b1;
        illegal_o   = 1'b0;
      end
      OP_SW: begin
        cls_o       = CLS_SW;
        ext_op_o    = EXT_SIGN;
        alu_src_b_o = 1'b1;
        illegal_o   = 1'b0;
      end
      // beq compares two registers; the sign-extended offset feeds the branch target
      OP_BEQ: begin
        cls_o      = CLS_BEQ;
        ext_op_o   = EXT_SIGN;
        alu_ctrl_o = ALU_SUB;
        illegal_o  = 1'b0;
      end
      OP_J: begin
        cls_o     = CLS_J;
        illegal_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath
// enables and selects, shared memory port request, retired-instruction count.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             pc_wr,
  output logic [1:0]       npc_sel,
  output logic             ir_wr,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       ext_op,
  output logic             alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       dbg_state
);

  // Memory handshake: mem_req stays high with mem_we stable until the cycle
  // in which mem_ready is sampled high; that cycle completes the access.

  state_e           state_q;
  logic             active_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  logic [3:0] dec_cls_raw;
  cls_e       dec_cls;
  logic [1:0] dec_ext;
  logic [2:0] dec_alu;
  logic       dec_src_b;
  logic       dec_illegal;

  mc_ctrl_decode u_decode (
    .op_i        (op),
    .funct_i     (funct),
    .cls_o       (dec_cls_raw),
    .ext_op_o    (dec_ext),
    .alu_ctrl_o  (dec_alu),
    .alu_src_b_o (dec_src_b),
    .illegal_o   (dec_illegal)
  );

  assign dec_cls = cls_e'(dec_cls_raw);

  // active_q keeps everything quiet until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= 1'b1;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
      if (active_q) begin
        case (state_q)
          S_FETCH:  if (mem_ready) state_q <= S_DECODE;
          S_DECODE: begin
            if (dec_illegal)           state_q <= S_ERR;
            else if (dec_cls == CLS_J) state_q <= S_FETCH;
            else                       state_q <= S_EXEC;
          end
          S_EXEC: begin
            if (dec_cls == CLS_BEQ)        state_q <= S_FETCH;
            else if (cls_uses_mem(dec_cls)) state_q <= S_MEM;
            else                           state_q <= S_WB;
          end
          S_MEM: begin
            if (mem_ready) state_q <= (dec_cls == CLS_SW) ? S_FETCH : S_WB;
          end
          S_WB:  state_q <= S_FETCH;
          S_ERR: state_q <= S_ERR;
          default: state_q <= S_FETCH;
        endcase
      end
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pc_wr      = 1'b0;
    npc_sel    = NPC_SEQ;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ext_op     = EXT_ZERO;
    alu_src_b  = 1'b0;
    alu_ctrl   = ALU_ADD;
    err        = 1'b0;
    retire     = 1'b0;
    if (active_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_wr   = mem_ready;
          pc_wr   = mem_ready;
        end
        S_DECODE: begin
          if (!dec_illegal && dec_cls == CLS_J) begin
            pc_wr   = 1'b1;
            npc_sel = NPC_JMP;
            retire  = 1'b1;
          end
        end
        S_EXEC: begin
          ext_op    = dec_ext;
          alu_src_b = dec_src_b;
          alu_ctrl  = dec_alu;
          if (dec_cls == CLS_BEQ) begin
            pc_wr   = alu_zero;
            npc_sel = NPC_BR;
            retire  = 1'b1;
          end
        end
        S_MEM: begin
          ext_op    = dec_ext;
          alu_src_b = dec_src_b;
          alu_ctrl  = dec_alu;
          mem_req   = 1'b1;
          mem_we    = (dec_cls == CLS_SW);
          retire    = (dec_cls == CLS_SW) && mem_ready;
        end
        S_WB: begin
          ext_op     = dec_ext;
          alu_src_b  = dec_src_b;
          alu_ctrl   = dec_alu;
          reg_wr     = 1'b1;
          reg_dst    = (dec_cls == CLS_R);
          mem_to_reg = (dec_cls == CLS_LW);
          retire     = 1'b1;
        end
        S_ERR: err = 1'b1;
        default: ;
      endcase
    end
  end

  assign instr_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: table of single-instruction runs plus
// hand-written stall, reset, illegal-instruction and counter-wrap sequences.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [5:0]  op        = 6'h00;
  logic [5:0]  funct     = 6'h00;
  logic        alu_zero  = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, pc_wr, ir_wr, reg_wr, reg_dst, mem_to_reg;
  logic        alu_src_b, err;
  logic [1:0]  npc_sel, ext_op;
  logic [2:0]  alu_ctrl, dbg_state;
  logic [31:0] instr_cnt;

  logic        s_mem_req, s_mem_we, s_pc_wr, s_ir_wr, s_reg_wr, s_reg_dst, s_mem_to_reg;
  logic        s_alu_src_b, s_err;
  logic [1:0]  s_npc_sel, s_ext_op;
  logic [2:0]  s_alu_ctrl, s_dbg_state;
  logic [3:0]  s_instr_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .pc_wr(pc_wr),
    .npc_sel(npc_sel), .ir_wr(ir_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .ext_op(ext_op), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .err(err), .instr_cnt(instr_cnt), .dbg_state(dbg_state)
  );

  mc_ctrl_fsm #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(s_mem_req), .mem_we(s_mem_we), .pc_wr(s_pc_wr),
    .npc_sel(s_npc_sel), .ir_wr(s_ir_wr), .reg_wr(s_reg_wr), .reg_dst(s_reg_dst),
    .mem_to_reg(s_mem_to_reg), .ext_op(s_ext_op), .alu_src_b(s_alu_src_b),
    .alu_ctrl(s_alu_ctrl), .err(s_err), .instr_cnt(s_instr_cnt), .dbg_state(s_dbg_state)
  );

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       az;
    int         lat;
    logic       pc_wr;
    logic [1:0] npc;
    logic       reg_wr;
    logic       reg_dst;
    logic       m2r;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] ext;
    logic       src_b;
    logic [2:0] alu;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] outs();
    return {mem_req, mem_we, pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, mem_to_reg,
            ext_op, alu_src_b, alu_ctrl, err};
  endfunction

  // One clock cycle: drive mem_ready at the falling edge, leave outputs to settle
  task automatic cyc(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask

  task automatic post_retire(input string name);
    @(posedge clk);
    #1;
    chk({name, " state after"}, 32'(dbg_state), 32'(S_FETCH));
    chk({name, " cnt"}, instr_cnt, 32'(exp_cnt));
    chk({name, " cnt4"}, 32'(s_instr_cnt), 32'(exp_cnt % 16));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("reset outs", 32'(outs()), 32'h0);
    chk("reset state", 32'(dbg_state), 32'(S_FETCH));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release outs", 32'(outs()), 32'h0);
    chk("release cnt", instr_cnt, 32'h0);
    exp_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int pc_n, ir_n, rg_n;
    pc_n = 0; ir_n = 0; rg_n = 0;
    op = v.op; funct = v.funct; alu_zero = v.az;
    for (int c = 1; c <= v.lat; c++) begin
      cyc(1'b1);
      if (pc_wr)  pc_n++;
      if (ir_wr)  ir_n++;
      if (reg_wr) rg_n++;
      if (c == 1)
        chk({v.name, " fetch"}, 32'({mem_req, mem_we, ir_wr, pc_wr, npc_sel}),
            32'({1'b1, 1'b0, 1'b1, 1'b1, 2'b00}));
      if (c == 3)
        chk({v.name, " exec sel"}, 32'({ext_op, alu_src_b, alu_ctrl}),
            32'({v.ext, v.src_b, v.alu}));
      if (c == v.lat) begin
        chk({v.name, " last"},
            32'({pc_wr, npc_sel, reg_wr, reg_dst, mem_to_reg, mem_req, mem_we}),
            32'({v.pc_wr, v.npc, v.reg_wr, v.reg_dst, v.m2r, v.mem_req, v.mem_we}));
        if (v.lat >= 4)
          chk({v.name, " held sel"}, 32'({ext_op, alu_src_b, alu_ctrl}),
              32'({v.ext, v.src_b, v.alu}));
      end
    end
    exp_cnt++;
    chk({v.name, " pulses"}, 32'({8'(pc_n), 8'(ir_n), 8'(rg_n)}),
        32'({8'(1 + int'(v.pc_wr)), 8'd1, 8'(v.reg_wr)}));
    post_retire(v.name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"addu",  6'h00, 6'h21, 1'b0, 4, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000};
    vecs[1]  = '{"subu",  6'h00, 6'h23, 1'b0, 4, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b001};
    vecs[2]  = '{"slt",   6'h00, 6'h2A, 1'b0, 4, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b011};
    vecs[3]  = '{"ori",   6'h0D, 6'h00, 1'b0, 4, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b010};
    vecs[4]  = '{"lui",   6'h0F, 6'h00, 1'b0, 4, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 3'b000};
    vecs[5]  = '{"addiu", 6'h09, 6'h00, 1'b0, 4, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 3'b000};
    vecs[6]  = '{"lw",    6'h23, 6'h00, 1'b0, 5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 3'b000};
    vecs[7]  = '{"sw",    6'h2B, 6'h00, 1'b0, 4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 3'b000};
    vecs[8]  = '{"beq_t", 6'h04, 6'h00, 1'b1, 3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 3'b001};
    vecs[9]  = '{"beq_n", 6'h04, 6'h00, 1'b0, 3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 3'b001};
    vecs[10] = '{"j",     6'h02, 6'h00, 1'b0, 2, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000};

    do_reset();
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // lw with three stalled MEM cycles: write-back lands on cycle 8
    op = OP_LW; funct = 6'h00; alu_zero = 1'b0;
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0);
      chk("lw stall", 32'({dbg_state, mem_req, mem_we, ext_op, reg_wr, pc_wr}),
          32'({S_MEM, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0}));
    end
    cyc(1'b1);
    chk("lw mem done", 32'({mem_req, mem_we, reg_wr}), 32'(3'b100));
    cyc(1'b1);
    chk("lw wb c8", 32'({reg_wr, mem_to_reg, reg_dst, ext_op}), 32'({3'b110, 2'b01}));
    exp_cnt++;
    post_retire("lw stall");

    // j with two stalled FETCH cycles
    op = OP_J;
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0);
      chk("fetch stall", 32'({mem_req, mem_we, ir_wr, pc_wr}), 32'(4'b1000));
    end
    cyc(1'b1);
    chk("fetch done", 32'({mem_req, ir_wr, pc_wr}), 32'(3'b111));
    cyc(1'b1);
    chk("j after stall", 32'({pc_wr, npc_sel}), 32'({1'b1, NPC_JMP}));
    exp_cnt++;
    post_retire("j stall");

    // reset asserted while sw is stalled in MEM
    op = OP_SW;
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    cyc(1'b0);
    chk("sw stall", 32'({mem_req, mem_we}), 32'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    chk("sw rst outs", 32'(outs()), 32'h0);
    chk("sw rst state", 32'({dbg_state, instr_cnt[3:0]}), 32'({S_FETCH, 4'h0}));
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("sw rel outs", 32'(outs()), 32'h0);
    cyc(1'b1);
    chk("restart fetch", 32'({dbg_state, mem_req, ir_wr}), 32'({S_FETCH, 2'b11}));
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("sw mem", 32'({mem_req, mem_we, reg_wr}), 32'(3'b110));
    exp_cnt++;
    post_retire("sw restart");

    // illegal funct under R-type
    op = OP_RTYPE; funct = 6'h3F;
    cyc(1'b1); cyc(1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1);
      chk("bad funct err", 32'({dbg_state, err, mem_req, pc_wr, ir_wr, reg_wr}),
          32'({S_ERR, 5'b10000}));
    end
    chk("bad funct cnt", instr_cnt, 32'(exp_cnt));
    do_reset();

    // 16 jumps wrap the 4-bit counter to zero
    for (int i = 0; i < 16; i++) run_vec(vecs[10]);
    chk("wrap cnt4", 32'(s_instr_cnt), 32'h0);
    chk("wrap cnt32", instr_cnt, 32'd16);

    // illegal opcode: sticky error, no memory requests
    op = 6'h3F; funct = 6'h00;
    cyc(1'b1); cyc(1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1);
      chk("op3f err", 32'({err, mem_req, mem_we, pc_wr, ir_wr, reg_wr}), 32'(6'b100000));
    end
    chk("op3f cnt", instr_cnt, 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
